dmem_responder: RTL and testbench

- Data-memory target that serves load/store requests issued by the pipeline's MEM stage.
- Uses a valid/ready request channel and a valid/ready response channel, with a fixed programmable access latency.
- Handles word/half/byte lanes, load sign/zero extension and misalignment detection.
- Emits a one-cycle store trace for the testbench.

---
 rtl/dmem_responder.sv | 254 +++++++++++++++++++++++++
 tb/tb_dmem_responder.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage: valid/ready request and response
// channels, fixed access latency, byte/half/word lanes with load extension,
// misalignment detection and a one-cycle store commit trace.
module dmem_responder #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned ADDR_SIZE   = 32,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [ADDR_SIZE-1:0] req_addr,
  input  logic [XLEN-1:0]      req_wdata,
  input  logic [ADDR_SIZE-1:0] req_pc,
  input  logic [1:0]           req_lwhb,
  input  logic [1:0]           req_swhb,
  input  logic                 req_lunsigned,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [XLEN-1:0]      resp_rdata,
  output logic                 resp_err,
  output logic                 wr_valid,
  output logic [ADDR_SIZE-1:0] wr_pc,
  output logic [ADDR_SIZE-1:0] wr_addr,
  output logic [XLEN-1:0]      wr_data
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam int unsigned NB    = XLEN / 8;
  localparam int unsigned CNT_W = (LATENCY < 2) ? 1 : $clog2(LATENCY);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Latched request
  logic                 we_q, we_d;
  logic [ADDR_SIZE-1:0] addr_q, addr_d;
  logic [XLEN-1:0]      wdata_q, wdata_d;
  logic [ADDR_SIZE-1:0] pc_q, pc_d;
  logic [1:0]           size_q, size_d;
  logic                 lu_q, lu_d;

  // Registered outputs
  logic                 req_ready_q, req_ready_d;
  logic                 resp_valid_q, resp_valid_d;
  logic [XLEN-1:0]      resp_rdata_q, resp_rdata_d;
  logic                 resp_err_q, resp_err_d;
  logic                 wr_valid_q, wr_valid_d;
  logic [ADDR_SIZE-1:0] wr_pc_q, wr_pc_d;
  logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d;
  logic [XLEN-1:0]      wr_data_q, wr_data_d;

  // Access operands and decode
  logic                 acc_we;
  logic [ADDR_SIZE-1:0] acc_addr;
  logic [XLEN-1:0]      acc_wdata;
  logic [ADDR_SIZE-1:0] acc_pc;
  logic [1:0]           acc_size;
  logic                 acc_lu;
  logic [IDX_W-1:0]     acc_idx;
  logic [1:0]           acc_off;
  logic                 is_half, is_byte, misal;
  logic [XLEN-1:0]      rd_word, rd_shift, load_val, wlane, merged;
  logic [NB-1:0]        be;
  logic                 do_access, mem_we;

  logic [XLEN-1:0] mem [DEPTH_WORDS];

  // Access uses the live inputs when it happens on the accept edge, else the latched request
  always_comb begin
    if (state_q == S_IDLE) begin
      acc_we    = req_we;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
      acc_pc    = req_pc;
      acc_size  = req_we ? req_swhb : req_lwhb;
      acc_lu    = req_lunsigned;
    end else begin
      acc_we    = we_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      acc_pc    = pc_q;
      acc_size  = size_q;
      acc_lu    = lu_q;
    end
    acc_idx = acc_addr[IDX_W+1:2];
    acc_off = acc_addr[1:0];
  end

  // Lane decode: alignment, load extraction/extension and store byte-merge
  always_comb begin
    is_half = (acc_size == 2'b01);
    is_byte = (acc_size == 2'b10);
    if (is_byte)      misal = 1'b0;
    else if (is_half) misal = acc_off[0];
    else              misal = (acc_off != 2'b00);

    rd_word  = mem[acc_idx];
    rd_shift = rd_word >> {acc_off, 3'b000};
    if (is_byte)
      load_val = {{(XLEN-8){~acc_lu & rd_shift[7]}}, rd_shift[7:0]};
    else if (is_half)
      load_val = {{(XLEN-16){~acc_lu & rd_shift[15]}}, rd_shift[15:0]};
    else
      load_val = rd_word;

    if (is_byte) begin
      be    = NB'(1) << acc_off;
      wlane = {NB{acc_wdata[7:0]}};
    end else if (is_half) begin
      be    = NB'(3) << acc_off;
      wlane = {(NB/2){acc_wdata[15:0]}};
    end else begin
      be    = '1;
      wlane = acc_wdata;
    end

    merged = rd_word;
    for (int b = 0; b < NB; b++) begin
      if (be[b]) merged[8*b +: 8] = wlane[8*b +: 8];
    end
  end

  // Next state, request capture and output computation
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    pc_d         = pc_q;
    size_d       = size_q;
    lu_d         = lu_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    wr_valid_d   = 1'b0;
    wr_pc_d      = wr_pc_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    do_access    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          pc_d    = req_pc;
          size_d  = req_we ? req_swhb : req_lwhb;
          lu_d    = req_lunsigned;
          if (LATENCY == 1) begin
            do_access = 1'b1;
            state_d   = S_RESP;
          end else begin
            cnt_d   = CNT_W'(LATENCY - 1);
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == CNT_W'(1)) begin
          do_access = 1'b1;
          state_d   = S_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RESP: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (do_access) begin
      resp_err_d   = misal;
      resp_rdata_d = (misal || acc_we) ? '0 : load_val;
      if (acc_we && !misal) begin
        wr_valid_d = 1'b1;
        wr_pc_d    = acc_pc;
        wr_addr_d  = {acc_addr[ADDR_SIZE-1:2], 2'b00};
        wr_data_d  = merged;
      end
    end

    req_ready_d  = (state_d == S_IDLE);
    resp_valid_d = (state_d == S_RESP);
  end

  // Memory write on the access edge; suppressed while in reset
  assign mem_we = do_access && acc_we && !misal && reset;

  // Storage array, deliberately not reset
  always_ff @(posedge clk) begin
    if (mem_we) mem[acc_idx] <= merged;
  end

  // State, request and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      pc_q         <= '0;
      size_q       <= 2'b00;
      lu_q         <= 1'b0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      wr_valid_q   <= 1'b0;
      wr_pc_q      <= '0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      pc_q         <= pc_d;
      size_q       <= size_d;
      lu_q         <= lu_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      wr_valid_q   <= wr_valid_d;
      wr_pc_q      <= wr_pc_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign wr_valid   = wr_valid_q;
  assign wr_pc      = wr_pc_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a LATENCY=2 instance carries the
// functional tests; LATENCY=1 and LATENCY=4 instances check timing and wrap.
module tb_dmem_responder;

  localparam int unsigned MAIN_LAT = 2;
  localparam int unsigned DEPTH    = 1024;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        wr;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [31:0] pc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        a_req_valid = 1'b0;
  logic        resp_ready = 1'b0;
  logic        a_resp_ready = 1'b1;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [31:0] req_pc = '0;
  logic [1:0]  req_lwhb = '0;
  logic [1:0]  req_swhb = '0;
  logic        req_lunsigned = 1'b0;

  logic        req_ready, resp_valid, resp_err, wr_valid;
  logic [31:0] resp_rdata, wr_pc, wr_addr, wr_data;
  logic        a1_req_ready, a1_resp_valid, a1_resp_err, a1_wr_valid;
  logic [31:0] a1_resp_rdata, a1_wr_pc, a1_wr_addr, a1_wr_data;
  logic        a4_req_ready, a4_resp_valid, a4_resp_err, a4_wr_valid;
  logic [31:0] a4_resp_rdata, a4_wr_pc, a4_wr_addr, a4_wr_data;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];
  logic [31:0] mdl [DEPTH];

  always #5 clk = ~clk;

  dmem_responder #(.XLEN(32), .ADDR_SIZE(32), .DEPTH_WORDS(DEPTH), .LATENCY(MAIN_LAT)) u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_pc(req_pc),
    .req_lwhb(req_lwhb), .req_swhb(req_swhb), .req_lunsigned(req_lunsigned),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .wr_valid(wr_valid), .wr_pc(wr_pc), .wr_addr(wr_addr),
    .wr_data(wr_data)
  );

  dmem_responder #(.XLEN(32), .ADDR_SIZE(32), .DEPTH_WORDS(DEPTH), .LATENCY(1)) u_lat1 (
    .clk(clk), .reset(reset), .req_valid(a_req_valid), .req_ready(a1_req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_pc(req_pc),
    .req_lwhb(req_lwhb), .req_swhb(req_swhb), .req_lunsigned(req_lunsigned),
    .resp_valid(a1_resp_valid), .resp_ready(a_resp_ready), .resp_rdata(a1_resp_rdata),
    .resp_err(a1_resp_err), .wr_valid(a1_wr_valid), .wr_pc(a1_wr_pc), .wr_addr(a1_wr_addr),
    .wr_data(a1_wr_data)
  );

  dmem_responder #(.XLEN(32), .ADDR_SIZE(32), .DEPTH_WORDS(DEPTH), .LATENCY(4)) u_lat4 (
    .clk(clk), .reset(reset), .req_valid(a_req_valid), .req_ready(a4_req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_pc(req_pc),
    .req_lwhb(req_lwhb), .req_swhb(req_swhb), .req_lunsigned(req_lunsigned),
    .resp_valid(a4_resp_valid), .resp_ready(a_resp_ready), .resp_rdata(a4_resp_rdata),
    .resp_err(a4_resp_err), .wr_valid(a4_wr_valid), .wr_pc(a4_wr_pc), .wr_addr(a4_wr_addr),
    .wr_data(a4_wr_data)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference behaviour of one access against the bench's memory image
  function automatic exp_t model(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] pc, input logic [1:0] sz, input logic lu);
    exp_t        e;
    logic [31:0] cur;
    logic [7:0]  b8;
    logic [15:0] h16;
    int          w, o;
    w = int'(addr[11:2]);
    o = int'(addr[1:0]);
    cur = mdl[w];
    e = '0;
    e.pc = pc;
    e.waddr = {addr[31:2], 2'b00};
    case (sz)
      2'b01:   e.err = addr[0];
      2'b10:   e.err = 1'b0;
      default: e.err = (addr[1:0] != 2'b00);
    endcase
    if (!e.err) begin
      if (we) begin
        case (sz)
          2'b10:   cur[8*o +: 8]  = wdata[7:0];
          2'b01:   cur[8*o +: 16] = wdata[15:0];
          default: cur = wdata;
        endcase
        mdl[w] = cur;
        e.wr = 1'b1;
        e.wdata = cur;
      end else begin
        case (sz)
          2'b10: begin
            b8 = cur[8*o +: 8];
            e.rdata = lu ? {24'h0, b8} : {{24{b8[7]}}, b8};
          end
          2'b01: begin
            h16 = cur[8*o +: 16];
            e.rdata = lu ? {16'h0, h16} : {{16{h16[15]}}, h16};
          end
          default: e.rdata = cur;
        endcase
      end
    end
    return e;
  endfunction

  task automatic preload(input logic [31:0] addr, input logic [31:0] val);
    mdl[addr[11:2]] = val;
    u_dut.mem[addr[11:2]] = val;
  endtask

  task automatic scramble();
    req_we        = 1'($urandom);
    req_addr      = $urandom;
    req_wdata     = $urandom;
    req_pc        = $urandom;
    req_lwhb      = 2'($urandom);
    req_swhb      = 2'($urandom);
    req_lunsigned = 1'($urandom);
  endtask

  // One request on the main instance; expected response queued at issue, compared at delivery
  task automatic run_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] sz, input logic lu, input int hold);
    exp_t        e;
    int          cyc, wr_cnt;
    logic        done;
    logic [31:0] pc, c_addr, c_data, c_pc;
    pc = {20'h40000, 10'($urandom_range(0, 1023)), 2'b00};
    sb.push_back(model(we, addr, wdata, pc, sz, lu));
    @(negedge clk);
    check("req_ready_idle", req_ready, 1);
    req_valid = 1'b1;
    req_we = we; req_addr = addr; req_wdata = wdata; req_pc = pc; req_lunsigned = lu;
    req_lwhb = we ? 2'($urandom) : sz;
    req_swhb = we ? sz : 2'($urandom);
    @(negedge clk);
    req_valid = 1'b0;
    scramble();
    cyc = 1; wr_cnt = 0; done = 1'b0;
    c_addr = '0; c_data = '0; c_pc = '0;
    while (!done) begin
      if (wr_valid) begin
        wr_cnt++; c_addr = wr_addr; c_data = wr_data; c_pc = wr_pc;
      end
      if (resp_valid || cyc >= 20) done = 1'b1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    check("latency", cyc, MAIN_LAT);
    e = sb.pop_front();
    if (resp_valid) begin
      check("resp_rdata", resp_rdata, e.rdata);
      check("resp_err", resp_err, e.err);
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        if (wr_valid) wr_cnt++;
        check("hold_valid", resp_valid, 1);
        check("hold_rdata", resp_rdata, e.rdata);
        check("hold_req_ready", req_ready, 0);
      end
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      if (wr_valid) wr_cnt++;
      check("post_req_ready", req_ready, 1);
      check("post_resp_valid", resp_valid, 0);
    end
    check("wr_pulses", wr_cnt, e.wr ? 1 : 0);
    if (e.wr) begin
      check("wr_addr", c_addr, e.waddr);
      check("wr_data", c_data, e.wdata);
      check("wr_pc", c_pc, e.pc);
    end
  endtask

  // Same request to the LATENCY=1 and LATENCY=4 instances; checks data and accept-to-valid distance
  task automatic aux_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp);
    int   c, lat1, lat4;
    logic got1, got4;
    @(negedge clk);
    check("a1_req_ready", a1_req_ready, 1);
    check("a4_req_ready", a4_req_ready, 1);
    a_req_valid = 1'b1;
    req_we = we; req_addr = addr; req_wdata = wdata; req_pc = 32'h100;
    req_lwhb = 2'b00; req_swhb = 2'b00; req_lunsigned = 1'b0;
    @(negedge clk);
    a_req_valid = 1'b0;
    scramble();
    c = 1; lat1 = 0; lat4 = 0; got1 = 1'b0; got4 = 1'b0;
    while (c <= 20 && !(got1 && got4)) begin
      if (!got1 && a1_resp_valid) begin
        got1 = 1'b1; lat1 = c;
        check("a1_rdata", a1_resp_rdata, exp);
      end
      if (!got4 && a4_resp_valid) begin
        got4 = 1'b1; lat4 = c;
        check("a4_rdata", a4_resp_rdata, exp);
      end
      if (!(got1 && got4)) begin
        @(negedge clk);
        c++;
      end
    end
    check("a1_latency", lat1, 1);
    check("a4_latency", lat4, 4);
  endtask

  initial begin
    scramble();
    repeat (2) @(negedge clk);
    check("rst_req_ready", req_ready, 1);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_rdata", resp_rdata, 0);
    check("rst_wr_valid", wr_valid, 0);
    check("rst_wr_data", wr_data, 0);
    reset = 1'b1;

    // Byte loads with sign / zero extension and other lane sizes
    preload(32'h10, 32'h8070_F0FF);
    run_req(0, 32'h11, 0, 2'b10, 0, 0);   // 0xFFFF_FFF0
    run_req(0, 32'h11, 0, 2'b10, 1, 0);   // 0x0000_00F0
    run_req(0, 32'h12, 0, 2'b01, 0, 0);   // 0xFFFF_8070
    run_req(0, 32'h13, 0, 2'b10, 1, 0);   // 0x0000_0080
    run_req(0, 32'h10, 0, 2'b01, 1, 0);   // 0x0000_F0FF
    run_req(0, 32'h10, 0, 2'b11, 0, 0);   // size 11 as word

    // Half store lane merge, then word load held off for 5 cycles
    preload(32'h10, 32'h1122_3344);
    run_req(1, 32'h12, 32'hDEAD_BEEF, 2'b01, 0, 0);
    run_req(0, 32'h10, 0, 2'b00, 0, 5);
    run_req(1, 32'h11, 32'h1234_56A5, 2'b10, 0, 0);
    run_req(0, 32'h10, 0, 2'b00, 0, 0);

    // Misaligned accesses
    preload(32'h04, 32'h5566_7788);
    run_req(0, 32'h06, 0, 2'b00, 0, 0);
    run_req(1, 32'h05, 32'h0000_ABCD, 2'b01, 0, 0);
    run_req(0, 32'h03, 0, 2'b01, 0, 0);
    run_req(0, 32'h04, 0, 2'b00, 0, 0);
    run_req(0, 32'h07, 0, 2'b10, 0, 0);

    // Reset while a store waits: discarded, outputs cleared, memory intact
    preload(32'h20, 32'hCAFE_BABE);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h1234_5678;
    req_swhb = 2'b00; req_pc = 32'h200;
    @(negedge clk);
    req_valid = 1'b0;
    reset = 1'b0;
    #1;
    check("arst_req_ready", req_ready, 1);
    check("arst_resp_valid", resp_valid, 0);
    check("arst_resp_rdata", resp_rdata, 0);
    check("arst_resp_err", resp_err, 0);
    check("arst_wr_valid", wr_valid, 0);
    check("arst_wr_pc", wr_pc, 0);
    check("arst_wr_addr", wr_addr, 0);
    check("arst_wr_data", wr_data, 0);
    repeat (2) @(negedge clk);
    check("arst_mem_word", u_dut.mem[8], 32'hCAFE_BABE);
    reset = 1'b1;
    run_req(0, 32'h20, 0, 2'b00, 0, 0);

    // Address wrap modulo memory size
    run_req(1, 32'h1000, 32'h0BAD_F00D, 2'b00, 0, 0);
    run_req(0, 32'h0000, 0, 2'b00, 0, 0);

    // Latency 1 and 4 instances: wrap plus timing
    aux_req(1, 32'h1000, 32'hA5A5_5A5A, 32'h0);
    aux_req(0, 32'h0000, 0, 32'hA5A5_5A5A);

    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
